// File: rtl/async_ram_responder.sv
// Emulates the async cellular-RAM (PSRAM) in on-chip memory: read access latency,
// minimum write pulse width, sticky protocol-violation flag and an access counter.
module async_ram_responder #(
  parameter int ADDR_W        = 8,
  parameter int ACCESS_CYCLES = 4,
  parameter int MIN_WR_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RamAdv,
  input  logic        RamClk,
  input  logic        RamCS,
  input  logic        MemOE,
  input  logic        MemWR,
  input  logic        RamLB,
  input  logic        RamUB,
  input  logic [26:1] MemAdr,
  input  logic [15:0] db_in,
  output logic [15:0] db_out,
  output logic        db_oe,
  output logic        timing_err,
  output logic [15:0] access_count
);

  localparam int CNT_MAX = ((ACCESS_CYCLES > MIN_WR_CYCLES) ? ACCESS_CYCLES : MIN_WR_CYCLES) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s_cs_q, s_oe_q, s_we_q, s_lb_q, s_ub_q;
  logic [ADDR_W-1:0]   s_adr_q, adr_q;
  logic [15:0]         s_db_q, wdat_q, db_out_q, access_count_q;
  logic                wlb_q, wub_q, db_oe_q, timing_err_q;
  logic                adr_chg, wr_end, wr_commit;
  logic [15:0]         mem [0:(1<<ADDR_W)-1];

  // Async-mode strobes and aliased upper address bits carry no information here.
  logic unused_ok;
  assign unused_ok = ^{RamAdv, RamClk, MemAdr[26:ADDR_W+1]};

  assign cnt_d     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
  assign adr_chg   = (s_adr_q != adr_q);
  assign wr_end    = s_we_q | s_cs_q;
  assign wr_commit = !rst && (state_q == WRITE) && wr_end && (cnt_q >= CNT_W'(MIN_WR_CYCLES));

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      if (!wlb_q) mem[adr_q][7:0]  <= wdat_q[7:0];
      if (!wub_q) mem[adr_q][15:8] <= wdat_q[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      s_cs_q         <= 1'b1;
      s_oe_q         <= 1'b1;
      s_we_q         <= 1'b1;
      s_lb_q         <= 1'b1;
      s_ub_q         <= 1'b1;
      s_adr_q        <= '0;
      s_db_q         <= '0;
      adr_q          <= '0;
      wdat_q         <= '0;
      wlb_q          <= 1'b1;
      wub_q          <= 1'b1;
      db_out_q       <= '0;
      db_oe_q        <= 1'b0;
      timing_err_q   <= 1'b0;
      access_count_q <= '0;
    end else begin
      s_cs_q  <= RamCS;
      s_oe_q  <= MemOE;
      s_we_q  <= MemWR;
      s_lb_q  <= RamLB;
      s_ub_q  <= RamUB;
      s_adr_q <= MemAdr[ADDR_W:1];
      s_db_q  <= db_in;

      case (state_q)
        IDLE: begin
          db_oe_q <= 1'b0;
          if (!s_cs_q && !s_we_q) begin
            state_q <= WRITE;
            cnt_q   <= CNT_W'(1);
            adr_q   <= s_adr_q;
            wdat_q  <= s_db_q;
            wlb_q   <= s_lb_q;
            wub_q   <= s_ub_q;
            if (!s_oe_q) timing_err_q <= 1'b1;
          end else if (!s_cs_q && !s_oe_q) begin
            state_q <= READ_WAIT;
            cnt_q   <= CNT_W'(1);
            adr_q   <= s_adr_q;
          end
        end

        READ_WAIT: begin
          if (s_cs_q || s_oe_q) begin
            state_q <= IDLE;
          end else if (adr_chg) begin
            cnt_q <= CNT_W'(1);
            adr_q <= s_adr_q;
          end else if (cnt_q == CNT_W'(ACCESS_CYCLES)) begin
            state_q        <= READ_DRIVE;
            db_oe_q        <= 1'b1;
            db_out_q       <= mem[adr_q];
            access_count_q <= access_count_q + 16'd1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        READ_DRIVE: begin
          if (!s_we_q) timing_err_q <= 1'b1;
          if (s_cs_q || s_oe_q) begin
            state_q <= IDLE;
            db_oe_q <= 1'b0;
          end else if (adr_chg) begin
            state_q <= READ_WAIT;
            db_oe_q <= 1'b0;
            cnt_q   <= CNT_W'(1);
            adr_q   <= s_adr_q;
          end
        end

        WRITE: begin
          // The memory commit itself happens in the array block via wr_commit.
          if (wr_end) begin
            state_q <= IDLE;
            if (cnt_q >= CNT_W'(MIN_WR_CYCLES)) access_count_q <= access_count_q + 16'd1;
            else                                timing_err_q   <= 1'b1;
          end else if (adr_chg) begin
            state_q      <= IDLE;
            timing_err_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_d;
            wdat_q <= s_db_q;
            wlb_q  <= s_lb_q;
            wub_q  <= s_ub_q;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign db_out       = db_out_q;
  assign db_oe        = db_oe_q;
  assign timing_err   = timing_err_q;
  assign access_count = access_count_q;

endmodule

// File: tb/tb_async_ram_responder.sv
// Bench for async_ram_responder: transaction-level model predicting every output per edge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_async_ram_responder;
  localparam int A    = 4;
  localparam int MINW = 3;
  localparam int AW   = 8;

  logic        clk = 1'b0;
  logic        rst, RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
  logic [26:1] MemAdr;
  logic [15:0] db_in, db_out, access_count;
  logic        db_oe, timing_err;

  always #5 clk = ~clk;

  async_ram_responder #(.ADDR_W(AW), .ACCESS_CYCLES(A), .MIN_WR_CYCLES(MINW)) dut (
    .clk(clk), .rst(rst), .RamAdv(RamAdv), .RamClk(RamClk), .RamCS(RamCS),
    .MemOE(MemOE), .MemWR(MemWR), .RamLB(RamLB), .RamUB(RamUB), .MemAdr(MemAdr),
    .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .timing_err(timing_err),
    .access_count(access_count)
  );

  // Reference model state
  logic [15:0] mmem [256];
  bit          mknown [256];
  logic        m_oe, m_err, m_dout_known;
  logic [15:0] m_dout, m_cnt;
  bit          chk_en = 0;
  int          errors = 0, checks = 0;
  int          last_first_oe;
  logic [15:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("db_oe", 32'(db_oe), 32'(m_oe));
      check("timing_err", 32'(timing_err), 32'(m_err));
      check("access_count", 32'(access_count), 32'(m_cnt));
      if (m_oe && m_dout_known) check("db_out", 32'(db_out), 32'(m_dout));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic cs, oe, we, lb, ub, input logic [26:1] a, input logic [15:0] d);
    RamCS = cs; MemOE = oe; MemWR = we; RamLB = lb; RamUB = ub; MemAdr = a; db_in = d;
  endtask

  task automatic model_reset();
    m_oe = 0; m_err = 0; m_cnt = 0; m_dout = 0; m_dout_known = 1;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    set_bus(1, 1, 1, 1, 1, MemAdr, db_in);
    for (int i = 0; i < n; i++) begin
      step();
      model_reset();
    end
    rst = 0;
  endtask

  // Write: WR low n cycles. Error/commit land on the edge after the release is captured.
  task automatic do_write(input logic [26:1] adr, input logic [15:0] dat, input logic lb, ub,
                          input int n, input bit oe_too, input bit chg_last, input bit vary);
    int          idx;
    logic [15:0] last;
    logic [26:1] a;
    idx  = int'(adr[AW:1]);
    last = dat;
    for (int j = 0; j <= n + 1; j++) begin
      if (j < n) begin
        a = (chg_last && j == n - 1) ? (adr ^ 26'h1) : adr;
        set_bus(0, oe_too ? 1'b0 : 1'b1, 0, lb, ub, a, vary ? (dat ^ 16'(j * 16'h0101)) : dat);
        if (!(chg_last && j == n - 1)) last = db_in;
      end else begin
        set_bus(1, 1, 1, 1, 1, adr, 16'h0);
      end
      step();
      if (j == 1 && oe_too) m_err = 1;
      if (chg_last) begin
        if (j == n) m_err = 1;
      end else if (j == n + 1) begin
        if (n >= MINW) begin
          if (!lb) mmem[idx][7:0]  = last[7:0];
          if (!ub) mmem[idx][15:8] = last[15:8];
          if (!lb && !ub) mknown[idx] = 1;
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  // Read: OE low m cycles; address switches to adr2 from cycle c (c>=m: no switch).
  // Each stable stretch [s,f) of captured edges drives data after edges s+A+1..f.
  task automatic do_read(input logic [26:1] adr1, adr2, input int m, c, we_at);
    int  i1, i2, f1;
    bit  in1, in2;
    i1 = int'(adr1[AW:1]);
    i2 = int'(adr2[AW:1]);
    f1 = (c < m) ? c : m;
    last_first_oe = -1;
    last_rd = 16'hxxxx;
    for (int j = 0; j <= m + 1; j++) begin
      if (j < m) set_bus(0, 0, (j == we_at) ? 1'b0 : 1'b1, 0, 0, (j < c) ? adr1 : adr2, 16'h0);
      else       set_bus(1, 1, 1, 1, 1, adr2, 16'h0);
      step();
      in1 = (j >= A + 1) && (j <= f1);
      in2 = (c < m) && (j >= c + A + 1) && (j <= m);
      if (j == A + 1 && in1) begin
        m_cnt = m_cnt + 16'd1; m_dout = mmem[i1]; m_dout_known = mknown[i1];
      end
      if (j == c + A + 1 && in2) begin
        m_cnt = m_cnt + 16'd1; m_dout = mmem[i2]; m_dout_known = mknown[i2];
      end
      m_oe = in1 || in2;
      if (we_at >= 0 && j == we_at + 1) m_err = 1;
      if (db_oe === 1'b1) begin
        if (last_first_oe < 0) last_first_oe = j;
        last_rd = db_out;
      end
    end
  endtask

  // Reset lands in the middle of a write that would otherwise have committed.
  task automatic do_rst_write(input logic [26:1] adr, input logic [15:0] dat);
    for (int j = 0; j <= 5; j++) begin
      if (j < 4) set_bus(0, 1, 0, 0, 0, adr, dat);
      else       set_bus(1, 1, 1, 1, 1, adr, 16'h0);
      rst = (j == 3);
      step();
      if (j == 3) model_reset();
    end
    rst = 0;
  endtask

  function automatic logic [26:1] rand_adr();
    logic [26:1] a;
    a = 26'($urandom());
    a[AW:1] = 8'($urandom_range(0, 7) * 29);
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mmem[i] = 16'h0;
      mknown[i] = 0;
    end
    rst = 1; RamAdv = 1; RamClk = 0;
    set_bus(1, 1, 1, 1, 1, 26'h0, 16'h0);
    model_reset();

    do_reset(2);
    chk_en = 1;
    check("rst_db_oe", 32'(db_oe), 32'd0);
    check("rst_db_out", 32'(db_out), 32'h0);
    check("rst_err", 32'(timing_err), 32'd0);
    check("rst_count", 32'(access_count), 32'd0);

    do_write(26'h05, 16'hBEEF, 0, 0, 7, 0, 0, 0);
    do_read(26'h05, 26'h05, 8, 8, -1);
    check("wr_rd_first_oe", 32'(last_first_oe), 32'd5);
    check("wr_rd_data", 32'(last_rd), 32'hBEEF);
    check("wr_rd_count", 32'(access_count), 32'd2);
    check("wr_rd_err", 32'(timing_err), 32'd0);

    do_write(26'h05, 16'h1234, 0, 1, 4, 0, 0, 0);
    do_read(26'h05, 26'h05, 8, 8, -1);
    check("lane_lo_data", 32'(last_rd), 32'hBE34);
    do_write(26'h05, 16'hFFFF, 1, 1, 4, 0, 0, 0);
    check("lane_none_count", 32'(access_count), 32'd5);
    do_read(26'h05, 26'h05, 6, 6, -1);
    check("lane_none_data", 32'(last_rd), 32'hBE34);

    do_write(26'h05, 16'hAAAA, 0, 0, 2, 0, 0, 0);
    check("short_wr_err", 32'(timing_err), 32'd1);
    do_read(26'h05, 26'h05, 6, 6, -1);
    check("short_wr_data", 32'(last_rd), 32'hBE34);

    do_read(26'h05, 26'h05, 3, 3, -1);
    check("abort_first_oe", 32'(last_first_oe), 32'hFFFFFFFF);
    check("abort_count", 32'(access_count), 32'd7);
    do_write(26'h06, 16'hC0DE, 0, 0, 4, 0, 0, 0);
    do_read(26'h05, 26'h06, 12, 2, -1);
    check("restart_first_oe", 32'(last_first_oe), 32'd7);
    check("restart_data", 32'(last_rd), 32'hC0DE);

    do_write(26'h07, 16'h5555, 0, 0, 4, 1, 0, 0);
    do_read(26'h107, 26'h107, 8, 8, -1);
    check("alias_data", 32'(last_rd), 32'h5555);
    check("alias_count", 32'(access_count), 32'd11);

    do_rst_write(26'h05, 16'hDEAD);
    check("rst_abort_err", 32'(timing_err), 32'd0);
    do_read(26'h05, 26'h05, 9, 9, 6);
    check("rst_abort_data", 32'(last_rd), 32'hBE34);
    check("rd_we_err", 32'(timing_err), 32'd1);
    check("rd_we_count", 32'(access_count), 32'd1);

    do_reset(1);
    do_write(26'h09, 16'h1111, 0, 0, 4, 0, 1, 0);
    check("wr_adr_chg_err", 32'(timing_err), 32'd1);
    check("wr_adr_chg_count", 32'(access_count), 32'd0);

    for (int k = 0; k < 300; k++) begin
      int          op, n, c;
      logic [26:1] a1, a2;
      op = $urandom_range(0, 11);
      a1 = rand_adr();
      if (op == 0) begin
        do_reset($urandom_range(1, 2));
      end else if (op <= 5) begin
        n = $urandom_range(1, 6);
        do_write(a1, 16'($urandom()), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 n, $urandom_range(0, 7) == 0, (n >= 2) && ($urandom_range(0, 9) == 0), 1);
      end else begin
        n = $urandom_range(1, 12);
        a2 = rand_adr();
        if (a2[AW:1] == a1[AW:1]) a2[1] = ~a2[1];
        c = ($urandom_range(0, 2) == 0 && n >= 2) ? $urandom_range(1, n - 1) : n;
        if (c >= n) a2 = a1;
        do_read(a1, a2, n, c, -1);
      end
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/async_ram_responder.md
Name: async_ram_responder

Overview:
- Synthesizable responder for the asynchronous cellular-RAM bus that our RAM controller drives: the chip-select, output-enable, write-enable, byte-lane and address pins, plus the 16-bit data bus.
- Emulates the external PSRAM in on-chip memory so the controller and audio path can be exercised on-board and in simulation without the real device.
- Enforces read access latency and minimum write pulse width, and flags protocol violations.

Parameters:
ADDR_W, 8, word-address bits implemented (depth 2^ADDR_W x 16); upper MemAdr bits ignored (aliasing).
ACCESS_CYCLES, 4, clk edges from entering READ_WAIT to driving data (>=1).
MIN_WR_CYCLES, 3, minimum sampled-low cycles of write enable for a valid write (>=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
RamAdv  in  1  address-valid, active low; ignored (async mode)
RamClk  in  1  RAM clock; ignored (async mode)
RamCS  in  1  chip select, active low
MemOE  in  1  output enable, active low
MemWR  in  1  write enable, active low
RamLB  in  1  lower byte enable, active low
RamUB  in  1  upper byte enable, active low
MemAdr  in  26  word address [26:1]; only [ADDR_W:1] used
db_in  in  16  data bus as seen by responder
db_out  out  16  read data toward bus
db_oe  out  1  responder drives bus when 1
timing_err  out  1  sticky protocol-violation flag
access_count  out  16  completed reads and writes, wraps at 0xFFFF

Behaviour:
- Input sampling: all bus inputs registered once per clk edge into s_*. FSM acts only on s_*. t0 is the edge that first captures a condition.
- Reset: state IDLE, db_oe=0, db_out=0, timing_err=0, access_count=0, counters 0. Memory contents are not reset; they are zero at configuration. Reset mid-operation aborts without commit.
- States: IDLE, READ_WAIT, READ_DRIVE, WRITE.
- IDLE (db_oe=0):
  - s_cs=0 & s_we=0 -> WRITE; cnt=1; latch addr and data.
  - else s_cs=0 & s_oe=0 -> READ_WAIT; cnt=1; latch addr.
  - If s_we and s_oe are both low: write wins and timing_err is set.
- READ_WAIT:
  - s_cs or s_oe high -> IDLE (abort, no count).
  - Address change -> restart with cnt=1 and new addr.
  - Otherwise cnt++. When cnt==ACCESS_CYCLES, the next edge -> READ_DRIVE and db_out=mem[addr].
  - db_oe rises at edge t0+ACCESS_CYCLES+1.
- READ_DRIVE (db_oe=1):
  - access_count++ on entry.
  - Stay while s_cs=0 & s_oe=0 and the address is unchanged.
  - Address change -> READ_WAIT (db_oe=0, cnt=1).
  - Deassert -> IDLE; db_oe=0 after that edge.
  - A write enable sampled low here sets timing_err; no write occurs.
- Reads: byte enables do not mask read data; the full word is returned.
- WRITE:
  - While s_we=0 & s_cs=0: cnt++ (saturating), latch s_db each cycle, latch s_lb/s_ub each cycle.
  - Address change -> timing_err=1, IDLE, no commit.
  - On s_we or s_cs high (edge t1): if cnt>=MIN_WR_CYCLES, commit at edge t1+1 the enabled lanes of the last latched data, access_count++, then IDLE. Otherwise timing_err=1, no commit, IDLE.
  - Both lanes disabled: no bytes change, but access_count still increments.
- Timing: s_oe low during WRITE is ignored. Back-to-back accesses need one IDLE cycle.
- timing_err: cleared only by rst.
- Width: cnt is wide enough for max(ACCESS_CYCLES, MIN_WR_CYCLES)+1 and saturates. access_count wraps.

Test Plan:
1. Reset: assert rst 2 cycles with inputs idle-high -> db_oe=0, db_out=0x0000, timing_err=0, access_count=0.
2. Write then read: MemAdr=0x05, db_in=0xBEEF, LB=UB=0, WR low 7 cycles; then OE low 8 cycles -> db_oe=1 from t0+5, db_out=0xBEEF, access_count=2, timing_err=0.
3. Byte lane: after scenario 2, write 0x1234 to 0x05 with LB=0, UB=1 -> read returns 0xBE34. Write with LB=UB=1 -> data unchanged, access_count increments.
4. Short write: WR low 2 cycles, data 0xAAAA at 0x05 -> timing_err=1, read still 0xBE34.
5. Read abort and restart: OE low 3 cycles -> db_oe never asserts, access_count unchanged. Address change 0x05->0x06 mid-READ_WAIT -> data of 0x06 appears ACCESS_CYCLES+1 edges after the change.
6. Conflict and alias: OE and WR low together, data 0x5555 at 0x07 -> write committed, timing_err=1. Read of 0x107 -> 0x5555.
